input_port_rc: RTL
==================

# input_port_rc

Input stage of the edge router: buffers incoming flits from one link in a DEPTH-entry FIFO and performs XY route computation on each flit at write time. It presents the head flit and its one-hot output-port label to the switch allocator, pops on the allocator's `ready`, and drives the `full` back-pressure seen by the upstream router's allocator. One instance sits in front of each L/N/E/W input of the south-edge router, which has no S port.

## Interface
Parameters:
- DEPTH, 8, FIFO entries (power of two)
- WIDTH, 3, pointer width, log2(DEPTH)
- DATASIZE, 40, flit width: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0]
- CUR_X, 0, router x coordinate (0..3)
- CUR_Y, 0, router y coordinate (0..3); y increases northward

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- in_data  in  DATASIZE  flit from link
- in_valid  in  1  in_data valid this cycle
- full  out  1  FIFO full; upstream must not push
- route_err  out  1  one-cycle pulse, flit dropped (route to absent S port)
- label  out  4  one-hot request for head flit: [0]=L, [1]=N, [2]=E, [3]=W; 0 when empty
- data_out  out  DATASIZE  head flit; 0 when empty
- ready  in  1  allocator grant; pops head at clock edge
- count  out  WIDTH+1  occupancy, 0..DEPTH

## Operation
- Route computation is combinational on in_data, with dx = dst[3:2] and dy = dst[1:0]:
  - dx > CUR_X gives E.
  - dx < CUR_X gives W.
  - dx == CUR_X and dy > CUR_Y gives N.
  - dx == CUR_X and dy < CUR_Y gives S (invalid for this router).
  - dx == CUR_X and dy == CUR_Y gives L.
- Storage: data memory DEPTH x DATASIZE plus label memory DEPTH x 4, written together at wr_ptr.
- Push condition: in_valid && !full && route != S.
  - On push, store the flit and its label, wr_ptr++, count++.
- Invalid route: in_valid && !full && route == S.
  - No store; route_err = 1 the next cycle.
- Pop condition: ready && count != 0.
  - On pop, rd_ptr++, count--.
  - ready while empty is ignored; no pointer movement.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Push attempted while full: flit ignored, no error flag. The upstream allocator honours `full`, so this is a protocol violation.
- Pointers are WIDTH bits and wrap DEPTH-1 to 0 naturally. count is the authoritative full/empty source.
- Outputs:
  - full = (count == DEPTH).
  - label = (count == 0) ? 4'b0000 : label_mem[rd_ptr].
  - data_out = (count == 0) ? 0 : data_mem[rd_ptr].
- The head label is stable until popped; the allocator uses label != 0 as its request.

## Timing
- Reset (rst_n low at a rising edge):
  - wr_ptr = rd_ptr = 0, count = 0, route_err = 0.
  - Hence full = 0, label = 0, data_out = 0.
  - Memories are not reset.
- Reset mid-operation discards all buffered flits. Outputs read as empty on the cycle after the reset edge.
- Latency: a flit pushed at edge k appears at data_out/label after edge k, i.e. cycle k+1, when the FIFO was empty.
- Pop: the head advances after the edge where ready=1. The next flit is visible the same cycle, or the FIFO reads empty.
- full is registered-derived and rises the cycle after the DEPTH-th push.
- Push-while-full with a same-cycle pop is rejected. full is evaluated before the pop, which keeps the upstream handshake simple.
- route_err is registered: high exactly one cycle after the offending edge, otherwise 0.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then idle, with CUR_X=1, CUR_Y=0:
  - Push dst=4'b1100 -> label=4'b0100 (E) next cycle, count=1.
  - ready=1 one cycle -> label=0, data_out=0, count=0.
- Routing sweep at CUR_X=1, CUR_Y=0, popping each flit:
  - dst 0000 -> W (1000).
  - dst 0101 -> N (0010).
  - dst 0100 -> L (0001).
  - dst 1100 -> E (0100).
- Invalid route: CUR_Y=1, dst=4'b0100 -> route_err=1 for one cycle, count stays 0, label=0.
- Fill: 8 consecutive pushes with ready=0 -> full=1 and count=8 after the 8th edge.
  - 9th push ignored.
  - Pop all 8 -> data in push order, timestamps 0..7.
- Wrap and concurrency:
  - Push 6, pop 6, then push 5 while popping each cycle.
  - Count holds steady, order is preserved across the pointer wrap, and no flit is lost or duplicated.
- Mid-operation reset: with 4 flits buffered, rst_n=0 one cycle -> count=0, full=0, label=0.
  - Subsequent push is visible after 1 cycle.

Source files
------------

// File: rtl/input_port_rc.sv
// Router input stage: a DEPTH-entry flit FIFO with XY route computation done at write time.
// The head flit and its one-hot port label go to the switch allocator; flits routed to the absent S port are dropped.
module input_port_rc #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40,
  parameter int CUR_X    = 0,
  parameter int CUR_Y    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                full,
  output logic                route_err,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  input  logic                ready,
  output logic [WIDTH:0]      count
);

  typedef enum logic [2:0] {
    RT_L,
    RT_N,
    RT_E,
    RT_W,
    RT_S
  } route_t;

  localparam logic [1:0]   CX        = CUR_X[1:0];
  localparam logic [1:0]   CY        = CUR_Y[1:0];
  localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH + 1)'(DEPTH);

  logic [DATASIZE-1:0] data_mem  [DEPTH];
  logic [3:0]          label_mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;

  logic [1:0] dx;
  logic [1:0] dy;
  route_t     route;
  logic [3:0] in_label;
  logic       push;
  logic       drop;
  logic       pop;
  logic       empty;

  assign dx = in_data[35:34];
  assign dy = in_data[33:32];

  always_comb begin
    route = RT_L;
    if (dx > CX)
      route = RT_E;
    else if (dx < CX)
      route = RT_W;
    else if (dy > CY)
      route = RT_N;
    else if (dy < CY)
      route = RT_S;
  end

  always_comb begin
    in_label = 4'b0000;
    case (route)
      RT_L:    in_label = 4'b0001;
      RT_N:    in_label = 4'b0010;
      RT_E:    in_label = 4'b0100;
      RT_W:    in_label = 4'b1000;
      default: in_label = 4'b0000;
    endcase
  end

  // full is judged on the registered count, so a same-cycle pop never frees room for a push
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign push  = in_valid && !full && (route != RT_S);
  assign drop  = in_valid && !full && (route == RT_S);
  assign pop   = ready && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      route_err <= 1'b0;
    end else begin
      route_err <= drop;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= in_data;
      label_mem[wr_ptr] <= in_label;
    end
  end

  assign label    = empty ? 4'b0000 : label_mem[rd_ptr];
  assign data_out = empty ? '0 : data_mem[rd_ptr];

endmodule
